cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter FifoDepth, default 4, per-requester queue depth; SHALL be a power of two, 2 or more.
REQ-002 Parameter PtrLength, default 1, queue pointer MSB index, log2(FifoDepth)-1.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 rdy  in  1  global enable; low freezes all state.
REQ-006 flush  in  1  exception flush from the ROB.
REQ-007 alu_valid  in  1  ALU completion request.
REQ-008 alu_pc, alu_data, alu_jpc  in  32 each  ALU completion tag, result and jump target.
REQ-009 alu_ready  out  1  ALU queue can accept this cycle.
REQ-010 slb_valid  in  1  store/load buffer completion request.
REQ-011 slb_pc, slb_data  in  32 each  SLB completion tag and result.
REQ-012 slb_ready  out  1  SLB queue can accept this cycle.
REQ-013 cdb_valid  out  1  one-cycle completion broadcast to the ROB.
REQ-014 cdb_pc, cdb_data, cdb_jpc  out  32 each  broadcast payload.
REQ-015 cdb_src  out  1  0 = ALU, 1 = SLB.

Function
REQ-016 Each requester SHALL own a FIFO of FifoDepth entries of {pc, data, jpc}; SLB entries SHALL store jpc = slb_pc + 4 (wrap mod 2^32).
REQ-017 x_ready SHALL equal (registered occupancy < FifoDepth); no same-cycle pass-through when full.
REQ-018 x_valid with x_ready high SHALL enqueue at that edge; x_valid with x_ready low SHALL be ignored, and the requester holds it.
REQ-019 Per edge, at most one FIFO head is popped and registered onto cdb_*; cdb_valid SHALL be high for exactly one cycle per pop.
REQ-020 Only one head non-empty: that head SHALL be granted.
REQ-021 Both non-empty: the requester not granted last SHALL win (round-robin); the last-grant register updates only on a grant.
REQ-022 Latency: a request enqueued at edge k SHALL appear on cdb_* no earlier than the cycle after edge k+1.
REQ-023 No pop: cdb_valid SHALL be 0; cdb_pc/data/jpc/src SHALL hold their previous values.
REQ-024 Pointers SHALL wrap modulo FifoDepth; a simultaneous enqueue and dequeue on one FIFO SHALL leave occupancy unchanged.
REQ-025 flush high with rdy high SHALL empty both FIFOs, set cdb_valid 0 and last-grant to SLB at that edge; same-edge enqueues SHALL be discarded.
REQ-026 rdy low SHALL block enqueue, pop and flush; all registers hold; x_ready reflects the held occupancy.

Reset
REQ-027 rst low SHALL immediately clear both FIFOs, set last-grant to SLB (ALU wins the first conflict), and set cdb_valid, cdb_pc, cdb_data, cdb_jpc and cdb_src to 0.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; after release, alu_ready and slb_ready SHALL be 1.

Configuration
REQ-029 Macro CDB_PERF_EN defined: the block SHALL add output conflict_cnt (out, 32 bits), counting edges with rdy high, no flush, and both heads non-empty; it SHALL reset to 0, wrap at 2^32 and ignore flush.
REQ-030 CDB_PERF_EN undefined: the conflict_cnt port and counter SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-031 Data and pc widths SHALL come from the shared parameters file (`DataLength`, `PcLength`); no local width literals.
REQ-032 The shared parameters file SHALL also hold the cdb_src encodings (SrcAlu = 0, SrcSlb = 1).
REQ-033 Sub-module cdb_fifo (parameterised depth and width, push/pop/full/empty/count) SHALL be instantiated once per requester.
REQ-034 Arbitration, the last-grant register, the output register and the optional counter SHALL live in cdb_arbiter.

Verification
REQ-035 Single ALU: alu_valid, pc=0x100, data=0x5, jpc=0x104 at edge 1 -> cdb_valid in the cycle after edge 2, pc 0x100, src 0.
REQ-036 Conflict: ALU pc=0x10 and SLB pc=0x20 at the same edge after reset -> broadcasts 0x10 (src 0) then 0x20 (src 1) on consecutive cycles; conflict_cnt=1 when enabled.
REQ-037 Backpressure: 5 back-to-back ALU requests with no pops (rdy low after the enqueues) -> alu_ready 0 after the 4th; the 5th is not accepted until a pop.
REQ-038 Flush: 3 SLB entries queued, flush pulsed -> no cdb_valid afterwards; slb_ready=1; a new ALU request is granted before a simultaneous SLB request.
REQ-039 Wrap: 10 alternating requests through each FIFO -> in-order broadcast per requester, no loss or duplication; SLB cdb_jpc = pc+4, including pc=0xFFFFFFFC giving jpc 0.
REQ-040 Async reset mid-stream, between clock edges -> cdb_valid, cdb_pc, cdb_data, cdb_jpc and cdb_src are 0 immediately; no queued entry is broadcast after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source encodings and the queued completion record for cdb_arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned DataLength    = 32;
  localparam int unsigned PcLength      = 32;
  localparam int unsigned PerfCntLength = 32;

  typedef enum logic {
    SrcAlu = 1'b0,
    SrcSlb = 1'b1
  } cdb_src_e;

  typedef struct packed {
    logic [PcLength-1:0]   pc;
    logic [DataLength-1:0] data;
    logic [PcLength-1:0]   jpc;
  } cdb_entry_t;

  localparam int unsigned EntryWidth = $bits(cdb_entry_t);

  // Fall-through target recorded for load/store completions.
  function automatic logic [PcLength-1:0] next_pc(input logic [PcLength-1:0] pc);
    return pc + PcLength'(4);
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-requester completion queue: power-of-two depth, wrapping pointers,
// registered occupancy, freeze on rdy low, clear on flush.
module cdb_fifo #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned PtrLength = 1,
  parameter int unsigned Width     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [Width-1:0]     din,
  output logic [Width-1:0]     dout,
  output logic                 full,
  output logic                 empty,
  output logic [PtrLength+1:0] count
);

  localparam logic [PtrLength+1:0] DepthCnt = (PtrLength+2)'(Depth);

  logic [Width-1:0]     mem_q [Depth];
  logic [Width-1:0]     mem_d [Depth];
  logic [PtrLength:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrLength:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrLength+1:0] cnt_q, cnt_d;
  logic                 do_push, do_pop;

  assign full  = (cnt_q == DepthCnt);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_push = rdy & ~flush & push & ~full;
  assign do_pop  = rdy & ~flush & pop & ~empty;

  // Next pointers, occupancy and storage; pointer width makes them wrap modulo Depth.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (rdy && flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + (PtrLength+2)'(do_push) - (PtrLength+2)'(do_pop);
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and SLB completions and broadcasts one
// per cycle to the ROB with round-robin between the two queue heads.
// Optional CDB_PERF_EN adds a conflict_cnt output counting contended edges.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned PtrLength = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  alu_valid,
  input  logic [PcLength-1:0]   alu_pc,
  input  logic [DataLength-1:0] alu_data,
  input  logic [PcLength-1:0]   alu_jpc,
  output logic                  alu_ready,
  input  logic                  slb_valid,
  input  logic [PcLength-1:0]   slb_pc,
  input  logic [DataLength-1:0] slb_data,
  output logic                  slb_ready,
  output logic                  cdb_valid,
  output logic [PcLength-1:0]   cdb_pc,
  output logic [DataLength-1:0] cdb_data,
  output logic [PcLength-1:0]   cdb_jpc,
  output logic                  cdb_src
`ifdef CDB_PERF_EN
  ,
  output logic [PerfCntLength-1:0] conflict_cnt
`endif
);

  localparam logic [PtrLength+1:0] DepthCnt = (PtrLength+2)'(FifoDepth);

  cdb_entry_t           alu_din, slb_din, alu_head, slb_head;
  logic                 alu_full, slb_full, alu_empty, slb_empty;
  logic [PtrLength+1:0] alu_count, slb_count;
  logic                 grant_alu, grant_slb;

  cdb_entry_t cdb_entry_q, cdb_entry_d;
  logic       cdb_valid_q, cdb_valid_d;
  cdb_src_e   cdb_src_q, cdb_src_d;
  cdb_src_e   last_grant_q, last_grant_d;

  assign alu_din = '{pc: alu_pc, data: alu_data, jpc: alu_jpc};
  assign slb_din = '{pc: slb_pc, data: slb_data, jpc: next_pc(slb_pc)};

  assign alu_ready = (alu_count < DepthCnt);
  assign slb_ready = (slb_count < DepthCnt);

  cdb_fifo #(
    .Depth    (FifoDepth),
    .PtrLength(PtrLength),
    .Width    (EntryWidth)
  ) u_alu_fifo (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .flush(flush),
    .push (alu_valid & ~alu_full),
    .pop  (grant_alu),
    .din  (alu_din),
    .dout (alu_head),
    .full (alu_full),
    .empty(alu_empty),
    .count(alu_count)
  );

  cdb_fifo #(
    .Depth    (FifoDepth),
    .PtrLength(PtrLength),
    .Width    (EntryWidth)
  ) u_slb_fifo (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .flush(flush),
    .push (slb_valid & ~slb_full),
    .pop  (grant_slb),
    .din  (slb_din),
    .dout (slb_head),
    .full (slb_full),
    .empty(slb_empty),
    .count(slb_count)
  );

  // Round-robin grant: a lone non-empty head wins, on contention the side not granted last.
  always_comb begin
    grant_alu = 1'b0;
    grant_slb = 1'b0;
    if (!alu_empty && (slb_empty || last_grant_q == SrcSlb)) begin
      grant_alu = 1'b1;
    end else if (!slb_empty) begin
      grant_slb = 1'b1;
    end
  end

  // Broadcast register and last-grant tracking; payload holds when nothing pops.
  always_comb begin
    cdb_valid_d  = cdb_valid_q;
    cdb_entry_d  = cdb_entry_q;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    if (rdy) begin
      if (flush) begin
        cdb_valid_d  = 1'b0;
        last_grant_d = SrcSlb;
      end else begin
        cdb_valid_d = grant_alu | grant_slb;
        if (grant_alu) begin
          cdb_entry_d  = alu_head;
          cdb_src_d    = SrcAlu;
          last_grant_d = SrcAlu;
        end else if (grant_slb) begin
          cdb_entry_d  = slb_head;
          cdb_src_d    = SrcSlb;
          last_grant_d = SrcSlb;
        end
      end
    end
  end

  // Output and arbitration state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_entry_q  <= '0;
      cdb_src_q    <= SrcAlu;
      last_grant_q <= SrcSlb;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_entry_q  <= cdb_entry_d;
      cdb_src_q    <= cdb_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_pc    = cdb_entry_q.pc;
  assign cdb_data  = cdb_entry_q.data;
  assign cdb_jpc   = cdb_entry_q.jpc;
  assign cdb_src   = cdb_src_q;

`ifdef CDB_PERF_EN
  logic [PerfCntLength-1:0] conflict_cnt_q, conflict_cnt_d;

  // Count edges where both heads contend; flush edges are not counted.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (rdy && !flush && !alu_empty && !slb_empty) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
